// File: rtl/shift_tx_arbiter.sv
// Two-requester serial transmitter: round-robin grant, parallel load, LSB-first shift-out,
// with a configurable idle gap between frames.
module shift_tx_arbiter #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             grant_id,
  output logic             done
);

  localparam int MAX_A = (WIDTH > 2) ? WIDTH : 2;
  localparam int MAX_C = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
  localparam int CW    = $clog2(MAX_C);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic             done_q, done_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;

  logic             winner_s;
  logic             handshake_s;
  logic             bit_last_s;
  logic             gap_last_s;

  assign bit_last_s = (bit_cnt_q == CW'(WIDTH - 1));
  assign gap_last_s = (GAP_CYCLES == 0) || (gap_cnt_q == CW'(GAP_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake_s) state_d = S_SHIFT;
        else             state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (bit_last_s) state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        else            state_d = S_SHIFT;
      end
      S_GAP: begin
        if (gap_last_s) state_d = S_IDLE;
        else            state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin: on a tie the requester that did not win last time is chosen
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_s = ~last_grant_q;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    handshake_s = (state_q == S_IDLE) && (req0_valid || req1_valid);
    req0_ready  = handshake_s && !winner_s;
    req1_ready  = handshake_s && winner_s;
  end

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (handshake_s) begin
          shift_d      = winner_s ? req1_data : req0_data;
          grant_id_d   = winner_s;
          last_grant_d = winner_s;
          bit_cnt_d    = {CW{1'b0}};
        end else begin
          shift_d = shift_q;
        end
      end
      S_SHIFT: begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        if (bit_last_s) begin
          done_d    = 1'b1;
          gap_cnt_d = {CW{1'b0}};
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (!gap_last_s) gap_cnt_d = gap_cnt_q + CW'(1);
        else             gap_cnt_d = gap_cnt_q;
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
    // Line outputs are registered from the next state so they line up with the shift cycles
    active_d = (state_d == S_SHIFT);
    serial_d = (state_d == S_SHIFT) ? shift_d[0] : 1'b0;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= {CW{1'b0}};
      gap_cnt_q    <= {CW{1'b0}};
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      done_q       <= 1'b0;
      serial_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      done_q       <= done_d;
      serial_q     <= serial_d;
      active_q     <= active_d;
    end
  end

  assign serial_out   = serial_q;
  assign frame_active = active_q;
  assign grant_id     = grant_id_q;
  assign done         = done_q;

endmodule

// File: doc/shift_tx_arbiter.md
Name: shift_tx_arbiter

Overview:
- Two-requester serial transmit controller. It owns a WIDTH-bit parallel-load, right-shifting register and arbitrates between two parallel-word sources with round-robin fairness.
- It loads the granted word, shifts it out LSB first on serial_out, and enforces a configurable idle gap between frames.
- It sits between word producers and a single serial line, and sequences the shift datapath that sources would otherwise drive directly.

Parameters:
- WIDTH, 8, word length in bits (>=2); also the number of shift cycles per frame
- GAP_CYCLES, 1, idle cycles inserted after each frame (0 allowed = back-to-back frames)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle (when valid & ready)
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- serial_out  output  1  serial bit stream, LSB first
- frame_active  output  1  high during every cycle a data bit is on serial_out
- grant_id  output  1  requester whose word is/was last shifted
- done  output  1  one-cycle pulse in the cycle after a frame's final bit

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE; shift register, bit counter and gap counter = 0
  - serial_out=0, frame_active=0, done=0, grant_id=0
  - last_grant=1, so requester 0 wins the first tie
  - Reset mid-frame aborts the frame immediately; no done pulse is generated.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - reqN_ready is combinational, high only in IDLE for the arbitration winner.
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: both readies 0.
  - At most one ready is high per cycle. Ready never asserts when valid is low.
- Handshake in cycle T (valid & ready):
  - shift_reg <= granted data; grant_id and last_grant <= winner; bit counter <= 0; state <= SHIFT.
- SHIFT:
  - serial_out = shift_reg[0]; frame_active=1.
  - Each cycle: shift_reg <= {1'b0, shift_reg[WIDTH-1:1]}; counter increments.
  - Data bit k appears in cycle T+1+k, for k = 0..WIDTH-1.
- After the bit WIDTH-1 cycle (T+WIDTH):
  - done=1 in cycle T+WIDTH+1, registered, exactly one cycle.
  - If GAP_CYCLES>0, state=GAP for GAP_CYCLES cycles, then IDLE.
  - If GAP_CYCLES=0, state=IDLE at T+WIDTH+1, and a new handshake may occur in that same cycle.
- Outside SHIFT: serial_out=0, frame_active=0.
- Latency: handshake to first bit = 1 cycle. Minimum frame period = 1 + WIDTH + GAP_CYCLES cycles (the IDLE cycle is merged when requesters are waiting).
- A requester held valid while busy sees ready=0 and must hold its data stable. The data is sampled only at the handshake edge; later changes do not affect the frame in flight.
- grant_id holds its value after a frame until the next handshake.
- Counters are sized ceil(log2) of max(WIDTH, GAP_CYCLES, 2). There is no wrap-around beyond the terminal count.

Test Plan:
- Reset, then req0_valid=1 with req0_data=8'hA5 for one handshake:
  - Handshake in the first IDLE cycle.
  - serial_out = 1,0,1,0,0,1,0,1 over the next 8 cycles with frame_active=1 and grant_id=0.
  - done=1 on the 9th cycle; 1 GAP cycle follows, then ready available again.
- Both requesters valid continuously (req0=8'h0F, req1=8'hF0):
  - Grants alternate 0,1,0,1, with req0 first after reset.
  - Frame period is 10 cycles; never two ready signals high together.
- req1 valid with 8'h81 while req0 frame in progress:
  - req1_ready stays 0 during SHIFT/GAP.
  - req1 is granted on the first IDLE cycle and emits 1,0,0,0,0,0,0,1.
- reset_n=0 during bit 3 of a frame:
  - Next cycle serial_out=0, frame_active=0, done never pulses, grant_id=0.
  - Next simultaneous request goes to req0.
- GAP_CYCLES=0, req0 valid continuously:
  - done pulse coincides with the next handshake cycle; frames separated by exactly one non-shift cycle.
- Data change after handshake (req0_data switched from 8'h3C to 8'hFF on cycle T+1):
  - Serial stream still 0,0,1,1,1,1,0,0.
